div_seq: RTL and testbench

- Multi-cycle integer divide sequencer for the EX stage; executes div.w, mod.w, div.wu and mod.wu beside the single-cycle ALU.
- Owns the operand latches, iteration counter, sign pre- and post-processing and the issue/writeback handshake.
- EX holds the instruction and stalls while busy is high; a pipeline cancel (exception or ertn) aborts via flush.

---
 rtl/div_seq_if.sv | 25 ++
 rtl/div_seq.sv | 133 +++++++++++++
 tb/tb_div_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Issue/writeback handshake bundle between the EX stage and the divide sequencer.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       div_op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output flush, in_valid, div_op, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, div_op, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for div.w/mod.w/div.wu/mod.wu, one quotient bit per cycle.
module div_seq #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] CALC = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] result_r;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic             out_valid_r;

  logic             is_signed;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             step_ok;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  assign is_signed = ~op_r[1];

  // quo_r doubles as the dividend shift register; quotient bits enter at the LSB.
  assign rem_sh  = {rem_r, quo_r[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dsr_r};
  assign step_ok = ~trial[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_r        <= 2'b00;
      quo_r       <= '0;
      dsr_r       <= '0;
      rem_r       <= '0;
      result_r    <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_r  <= bus.div_op;
            quo_r <= bus.src1;
            dsr_r <= bus.src2;
            state <= PREP;
          end
        end
        // PREP: magnitudes and sign bookkeeping
        PREP: begin
          rem_r <= '0;
          cnt   <= '0;
          if (is_signed) begin
            quo_r <= abs_val($signed(quo_r));
            dsr_r <= abs_val($signed(dsr_r));
            // A zero divisor must give an all-ones quotient whatever the dividend sign.
            q_neg <= (quo_r[WIDTH-1] ^ dsr_r[WIDTH-1]) & (|dsr_r);
            r_neg <= quo_r[WIDTH-1];
          end else begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
          end
          if (EARLY_ZERO && (dsr_r == '0)) begin
            result_r <= op_r[0] ? quo_r : '1;
            state    <= DONE;
          end else begin
            state <= CALC;
          end
        end
        // CALC: one restoring step per cycle, MSB first
        CALC: begin
          rem_r <= step_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], step_ok};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            state <= FIX;
          end
        end
        // FIX: restore signs and pick quotient or remainder
        FIX: begin
          result_r <= op_r[0] ? neg_if(rem_r, r_neg) : neg_if(quo_r, q_neg);
          state    <= DONE;
        end
        // DONE: raise out_valid one cycle after entry, hold result until taken
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed checks of div_seq against an arithmetic reference, with and without early zero exit.
module tb_div_seq;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  div_seq_if #(.WIDTH(32)) bus ();
  div_seq_if #(.WIDTH(32)) bus_nz ();

  div_seq #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  div_seq #(.WIDTH(32), .EARLY_ZERO(1'b0)) dut_nz (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nz)
  );

  // Both instances see identical requests.
  assign bus_nz.flush     = bus.flush;
  assign bus_nz.in_valid  = bus.in_valid;
  assign bus_nz.div_op    = bus.div_op;
  assign bus_nz.src1      = bus.src1;
  assign bus_nz.src2      = bus.src2;
  assign bus_nz.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'h0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    q = x / y;
    r = x % y;
    return op[0] ? r[31:0] : q[31:0];
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100 && !(bus.in_ready && bus_nz.in_ready); i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one request with out_ready high; report each instance's result and latency (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r1, output logic [31:0] r2, output int l1, output int l2);
    l1 = -1; l2 = -1; r1 = 32'hDEAD_BEEF; r2 = 32'hDEAD_BEEF;
    wait_idle();
    bus.div_op = op; bus.src1 = a; bus.src2 = b;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.div_op = 2'($urandom); bus.src1 = $urandom; bus.src2 = $urandom;
    for (int k = 1; k <= 60 && (l1 < 0 || l2 < 0); k++) begin
      @(posedge clk); #1;
      if (l1 < 0 && bus.out_valid) begin l1 = k; r1 = bus.result; end
      if (l2 < 0 && bus_nz.out_valid) begin l2 = k; r2 = bus_nz.result; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.div_op = 2'b00;
    bus.src1 = '0; bus.src2 = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b result=%h, required 1 0 0 00000000",
               bus.in_ready, bus.busy, bus.out_valid, bus.result);
    end
    n_checks++;
    if (bus_nz.in_ready !== 1'b1 || bus_nz.busy !== 1'b0 || bus_nz.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_nz: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
               bus_nz.in_ready, bus_nz.busy, bus_nz.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [11] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [31:0] as  [11] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    logic [31:0] bs  [11] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd2, 32'd10, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exp [11] = '{32'hFFFF_FFF2, 32'h2, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'h5,
                             32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    logic [31:0] r1, r2;
    int l1, l2, el1;
    for (int i = 0; i < 11; i++) begin
      run_op(ops[i], as[i], bs[i], r1, r2, l1, l2);
      el1 = (bs[i] == 32'h0) ? 2 : 35;
      n_checks++;
      if (r1 !== exp[i] || l1 != el1) begin
        n_fail++;
        $display("FAIL directed_%0d: result=%h latency=%0d, required %h at %0d", i, r1, l1, exp[i], el1);
      end
      n_checks++;
      if (r2 !== exp[i] || l2 != 35) begin
        n_fail++;
        $display("FAIL directed_nz_%0d: result=%h latency=%0d, required %h at 35", i, r2, l2, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] a, b, exp, r1, r2;
    logic [1:0]  op;
    int l1, l2;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = specials[$urandom_range(0, 5)];
        2, 3:    b = $urandom_range(1, 300);
        default: b = $urandom;
      endcase
      exp = ref_div(op, a, b);
      run_op(op, a, b, r1, r2, l1, l2);
      n_checks++;
      if (r1 !== exp || l1 != ((b == 32'h0) ? 2 : 35)) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h latency=%0d, required %h", i, op, a, b, r1, l1, exp);
      end
      n_checks++;
      if (r2 !== exp || l2 != 35) begin
        n_fail++;
        $display("FAIL random_nz_%0d op=%0d a=%h b=%h: result=%h latency=%0d, required %h at 35", i, op, a, b, r2, l2, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    wait_idle();
    bus.out_ready = 1'b0;
    bus.div_op = 2'b10; bus.src1 = 32'd1000; bus.src2 = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (k = 0; k < 60 && !bus.out_valid; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (!bus.out_valid) begin
      n_fail++;
      $display("FAIL backpressure_timeout: out_valid=%b, required 1 within 60 cycles", bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.result !== 32'd142 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: result=%h in_ready=%b busy=%b out_valid=%b, required 0000008e 0 1 1",
                 i, bus.result, bus.in_ready, bus.busy, bus.out_valid);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
               bus.in_ready, bus.busy, bus.out_valid);
    end
    bus.div_op = 2'b01; bus.src1 = 32'd1000; bus.src2 = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_accept: busy=%b in_ready=%b, required 1 0", bus.busy, bus.in_ready);
    end
    for (k = 0; k < 60 && !bus.out_valid; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd6) begin
      n_fail++;
      $display("FAIL back_to_back_result: out_valid=%b result=%h, required 1 00000006", bus.out_valid, bus.result);
    end
    bus.out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_flush();
    logic seen;
    wait_idle();
    bus.out_ready = 1'b1;
    bus.div_op = 2'b10; bus.src1 = 32'd12345; bus.src2 = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'd6) begin
      n_fail++;
      $display("FAIL flush_calc: in_ready=%b busy=%b out_valid=%b result=%h, required 1 0 0 00000006",
               bus.in_ready, bus.busy, bus.out_valid, bus.result);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus_nz.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_result: out_valid_seen=%b, required 0", seen);
    end
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle_no_accept: busy=%b in_ready=%b, required 0 1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r1, r2;
    int l1, l2;
    wait_idle();
    bus.out_ready = 1'b1;
    bus.div_op = 2'b00; bus.src1 = 32'd999; bus.src2 = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_mid: out_valid=%b result=%h busy=%b in_ready=%b, required 0 00000000 0 1",
               bus.out_valid, bus.result, bus.busy, bus.in_ready);
    end
    #1 reset = 1'b0;
    run_op(2'b00, 32'd999, 32'd4, r1, r2, l1, l2);
    n_checks++;
    if (r1 !== 32'd249 || l1 != 35) begin
      n_fail++;
      $display("FAIL after_reset_op: result=%h latency=%0d, required 000000f9 at 35", r1, l1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
